alu_share_ctrl: RTL
===================

// Module: alu_share_ctrl
// PURPOSE
//  Shares one combinational 32-bit ALU (alu_new) between NREQ requesters.
//  Round-robin arbitration; accepted operands and function code are registered and driven to the ALU;
//  the registered result is returned on one response port tagged with the requester id.
//  Sits between the CPU-side requesters and a single alu_new instance wired at the top level.
// PARAMETERS
//  NREQ   4   number of requesters, 2..8
//  ID_W   2   requester id width, must equal clog2(NREQ)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        async active-low reset
//  req_valid  in   NREQ     request i valid
//  req_ready  out  NREQ     request i accepted this cycle
//  req_a      in   NREQ*32  operand a, requester i in [32*i+31:32*i]
//  req_b      in   NREQ*32  operand b, same packing
//  req_f      in   NREQ*4   function code, requester i in [4*i+3:4*i]
//  alu_a      out  32       to ALU a
//  alu_b      out  32       to ALU b
//  alu_f      out  4        to ALU f
//  alu_r      in   32       from ALU r (combinational)
//  rsp_valid  out  1        result valid
//  rsp_ready  in   1        consumer accepts result
//  rsp_id     out  ID_W     requester that owns rsp_r
//  rsp_r      out  32       registered ALU result
//  busy       out  1        state != IDLE
//  op_cnt     out  16       completed responses, wraps
// BEHAVIOUR
//  - FSM states: IDLE, EXEC, RESP.
//  - IDLE: if any req_valid, winner = first valid index after rr_ptr, searching modulo NREQ.
//    req_ready is one-hot on the winner and combinational from state, req_valid and rr_ptr.
//    Accept at edge E0 (valid & ready): capture a/b/f into a_q/b_q/f_q and the id; rr_ptr <= winner; go to EXEC.
//  - EXEC: one cycle. alu_a/alu_b/alu_f = a_q/b_q/f_q. At E1: rsp_r <= alu_r, rsp_valid <= 1; go to RESP.
//  - RESP: rsp_valid, rsp_r and rsp_id are held stable. On rsp_valid & rsp_ready at edge E2:
//    rsp_valid <= 0, op_cnt++, go to IDLE.
//  - Latency: rsp_valid is high from E1 (one cycle after accept).
//  - Throughput: 1 op per 3 cycles when rsp_ready = 1. The next accept is at E3 at the earliest.
//  - req_ready = 0 in EXEC and RESP. No request is accepted while a response is pending.
//  - Requesters hold valid, a, b and f until ready. A dropped valid without ready is ignored; nothing is captured.
//  - f is passed through unmodified; all 16 codes are legal:
//    000x add (x=1: a+1), 001x sub (x=1: a-1), 010 mul (a[15:0]*b[15:0]),
//    011 and, 100 or, 101 not a, 110 xor, 111 shift.
//  - alu_a/alu_b/alu_f hold a_q/b_q/f_q in every state.
//  - Arithmetic wraps mod 2^32 inside the ALU; the controller performs no width changes.
//  - Reset, async and effective at any point including mid-EXEC/RESP:
//    state=IDLE, rr_ptr=NREQ-1 (req 0 wins first), a_q=b_q=0, f_q=0, rsp_valid=0,
//    rsp_r=0, rsp_id=0, op_cnt=0, req_ready=0. An in-flight op is dropped with no response.
//  - op_cnt wraps 16'hFFFF -> 0.
// STRUCTURE
//  - alu_pkg: DATA_W=32, FUNC_W=4, named localparams for the f codes (F_ADD..F_SHIFT), FSM state encodings.
//  - Sub-module alu_rr_grant: comb, inputs req[NREQ], ptr[ID_W]; outputs gnt_onehot[NREQ], gnt_id[ID_W], any.
//  - The top level instantiates alu_share_ctrl and alu_new back to back; the controller has no arithmetic.
// TESTING
//  1. req0 only: a=5, b=3, f=0000 -> req_ready[0] at E0; rsp_valid at E1 with rsp_id=0, rsp_r=8.
//  2. All 4 valid permanently, rsp_ready=1 -> accept order 0,1,2,3,0, accepts 3 cycles apart, op_cnt=5.
//  3. rsp_ready=0 for 5 cycles in RESP -> rsp_* stable; req_ready=0 throughout; accept resumes after the handshake.
//  4. rst_n low during EXEC -> rsp_valid=0 and busy=0 immediately. After release with req0 and req2 valid, req0 wins.
//  5. Codes: f=0011, a=0 -> rsp_r=32'hFFFF_FFFF.
//     f=0100, a=32'h0001_0003, b=32'h0002_0004 -> 32'd12.
//     f=1010, a=0 -> 32'hFFFF_FFFF.
//  6. Preload op_cnt near wrap (force or 65535 ops) -> 16'hFFFF then 16'h0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller.
// Data widths, ALU function codes and controller FSM states.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int FUNC_W = 4;

    // Operation group is f[3:1]; f[0] selects the variant.
    localparam logic [2:0] F_ADD   = 3'd0;
    localparam logic [2:0] F_SUB   = 3'd1;
    localparam logic [2:0] F_MUL   = 3'd2;
    localparam logic [2:0] F_AND   = 3'd3;
    localparam logic [2:0] F_OR    = 3'd4;
    localparam logic [2:0] F_NOT   = 3'd5;
    localparam logic [2:0] F_XOR   = 3'd6;
    localparam logic [2:0] F_SHIFT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_grant.sv
// Round-robin grant: first asserted request after ptr,
// searching upward modulo NREQ.
module alu_rr_grant #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [NREQ-1:0] o_gnt_onehot,
    output logic [ID_W-1:0] o_gnt_id,
    output logic            o_any
);

    logic [ID_W-1:0] w_idx;

    // Scan the requests starting just after the last winner.
    always_comb begin
        o_gnt_onehot = '0;
        o_gnt_id     = '0;
        o_any        = 1'b0;
        w_idx        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = ID_W'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_idx]) begin
                o_any               = 1'b1;
                o_gnt_onehot[w_idx] = 1'b1;
                o_gnt_id            = w_idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between NREQ requesters.
// Round-robin accept, one EXEC cycle, held response.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*FUNC_W-1:0] req_f,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [FUNC_W-1:0]      alu_f,
    input  logic [DATA_W-1:0]      alu_r,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DATA_W-1:0]      rsp_r,
    output logic                   busy,
    output logic [15:0]            op_cnt
);

    state_t r_state;
    state_t w_state_nxt;

    logic [ID_W-1:0]   r_ptr;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [FUNC_W-1:0] r_f;
    logic [ID_W-1:0]   r_id;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_r;
    logic [15:0]       r_op_cnt;

    logic [NREQ-1:0]   w_gnt;
    logic [ID_W-1:0]   w_gnt_id;
    logic              w_any;
    logic              w_accept;
    logic              w_exec;
    logic              w_done;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [FUNC_W-1:0] w_f;

    alu_rr_grant #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_grant (
        .i_req        (req_valid),
        .i_ptr        (r_ptr),
        .o_gnt_onehot (w_gnt),
        .o_gnt_id     (w_gnt_id),
        .o_any        (w_any)
    );

    // Ready is offered only while idle and out of reset.
    assign req_ready = (r_state == ST_IDLE && rst_n) ? w_gnt : '0;

    // Select the winning requester's operands.
    always_comb begin
        w_a = '0;
        w_b = '0;
        w_f = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_a = req_a[i*DATA_W +: DATA_W];
                w_b = req_b[i*DATA_W +: DATA_W];
                w_f = req_f[i*FUNC_W +: FUNC_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-state strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_exec      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, result capture and completion count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= ID_W'(NREQ - 1);
            r_a         <= '0;
            r_b         <= '0;
            r_f         <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_r     <= '0;
            r_op_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= w_a;
                r_b   <= w_b;
                r_f   <= w_f;
                r_id  <= w_gnt_id;
                r_ptr <= w_gnt_id;
            end
            if (w_exec) begin
                r_rsp_r     <= alu_r;
                r_rsp_valid <= 1'b1;
            end
            if (w_done) begin
                r_rsp_valid <= 1'b0;
                r_op_cnt    <= r_op_cnt + 16'd1;
            end
        end
    end

    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_f     = r_f;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_r     = r_rsp_r;
    assign busy      = (r_state != ST_IDLE);
    assign op_cnt    = r_op_cnt;

endmodule
